// File: rtl/tt_mux_pkg.sv
// Shared definitions for the project mux bus.
// - state_e       : selection controller FSM states
// - IW_W / OW_W   : widths of the broadcast input word and the per-project output word
// - IW_* / OW_*   : bit offsets of the fields inside iw and ow
// - is_live()     : true in the states where a project is enabled and clocked
package tt_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ARM,
    ST_ACTIVE
  } state_e;

  localparam int unsigned IW_W = 18;
  localparam int unsigned OW_W = 24;

  // iw = {uio_in, ui_in, proj_rst_n, proj_clk}
  localparam int unsigned IW_CLK   = 0;
  localparam int unsigned IW_RST_N = 1;
  localparam int unsigned IW_UI    = 2;
  localparam int unsigned IW_UIO   = 10;

  // ow = {uio_oe, uio_out, uo_out}
  localparam int unsigned OW_UO      = 0;
  localparam int unsigned OW_UIO_OUT = 8;
  localparam int unsigned OW_UIO_OE  = 16;

  function automatic logic is_live(state_e s);
    return (s == ST_ARM) || (s == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/tt_proj_select_ctrl_if.sv
// Project mux bus between the selection controller and the project wrappers.
// - ena : one-hot project enable (bit i = project i)
// - iw  : broadcast input word {uio_in, ui_in, proj_rst_n, proj_clk}
// - ow  : concatenated output words, slice i = {uio_oe, uio_out, uo_out} of project i
// master = selection controller, slave = project side.
interface tt_proj_select_ctrl_if
  import tt_mux_pkg::*;
#(
  parameter int unsigned N_PROJ = 16
);

  logic [N_PROJ-1:0]      ena;
  logic [IW_W-1:0]        iw;
  logic [OW_W*N_PROJ-1:0] ow;

  modport master (
    output ena,
    output iw,
    input  ow
  );

  modport slave (
    input  ena,
    input  iw,
    output ow
  );

endinterface

// File: rtl/tt_clk_gate.sv
// Glitch-free clock gate: enable is captured by a latch that is transparent
// only while clk is low, then ANDed with clk, so the gated clock only ever
// starts or stops on whole high pulses. Swapped for the library ICG cell at
// synthesis.
// - clk  : source clock
// - en   : gate enable (must be launched from a clk rising-edge flop)
// - gclk : gated clock
module tt_clk_gate (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_l;

  always_latch begin
    if (!clk) en_l <= en;
  end

  assign gclk = clk & en_l;

endmodule

// File: rtl/tt_proj_select_ctrl.sv
// Project selection controller: upstream stage of every project wrapper.
// Decodes the async chip control pins into a project index, enables exactly
// one project, drives the broadcast input word and returns the selected
// project's output word to the pads.
// - clk, rst_n           : system clock, async active-low reset
// - ctrl_sel_rst_n       : async pin, low clears the selection counter
// - ctrl_sel_inc         : async pin, each rising edge increments the selection
// - ctrl_ena             : async pin, high requests activation of the selection
// - pad_rst_n            : user reset for the active project
// - pad_ui_in/uio_in     : user inputs, broadcast combinationally on iw
// - pad_uo_out/uio_*     : selected project's outputs (zero unless armed/active)
// - proj                 : project mux bus (ena, iw, ow)
// - sel_addr             : current selection counter
module tt_proj_select_ctrl
  import tt_mux_pkg::*;
#(
  parameter int unsigned N_PROJ   = 16,
  parameter int unsigned ADDR_W   = $clog2(N_PROJ),
  parameter int unsigned RST_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctrl_sel_rst_n,
  input  logic                 ctrl_sel_inc,
  input  logic                 ctrl_ena,
  input  logic                 pad_rst_n,
  input  logic [7:0]           pad_ui_in,
  input  logic [7:0]           pad_uio_in,
  output logic [7:0]           pad_uo_out,
  output logic [7:0]           pad_uio_out,
  output logic [7:0]           pad_uio_oe,
  tt_proj_select_ctrl_if.master proj,
  output logic [ADDR_W-1:0]    sel_addr
);

  // Synchroniser bit order: {pad_rst_n, ena, sel_inc, sel_rst_n}.
  // sel_rst_n resets to its idle-high level so reset does not look like a clear.
  localparam logic [3:0] SYNC_RST = 4'b0001;

  logic [3:0] sync1_q, sync2_q;
  logic       sel_rst_s, inc_s, ena_s, pad_rst_s;
  logic       inc_prev_q, inc_rise;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          hold_q, hold_d;
  logic                lock_q, lock_d;
  logic [N_PROJ-1:0]   ena_q, ena_d;
  logic                rst_out_q, rst_out_d;
  logic                clk_en_q, clk_en_d;
  logic                exit_req;
  logic                gclk;
  logic [OW_W-1:0]     ow_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= SYNC_RST;
      sync2_q    <= SYNC_RST;
      inc_prev_q <= 1'b0;
    end else begin
      sync1_q    <= {pad_rst_n, ctrl_ena, ctrl_sel_inc, ctrl_sel_rst_n};
      sync2_q    <= sync1_q;
      inc_prev_q <= inc_s;
    end
  end

  assign sel_rst_s = sync2_q[0];
  assign inc_s     = sync2_q[1];
  assign ena_s     = sync2_q[2];
  assign pad_rst_s = sync2_q[3];
  assign inc_rise  = inc_s & ~inc_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      hold_q    <= '0;
      lock_q    <= 1'b0;
      ena_q     <= '0;
      rst_out_q <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      lock_q    <= lock_d;
      ena_q     <= ena_d;
      rst_out_q <= rst_out_d;
      clk_en_q  <= clk_en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    hold_d   = hold_q;
    // After leaving ARM/ACTIVE the request must be dropped before the next
    // activation, otherwise an increment would immediately arm the next project.
    lock_d   = lock_q & ena_s;
    exit_req = !ena_s || !sel_rst_s || inc_rise;

    unique case (state_q)
      ST_IDLE: begin
        if (!sel_rst_s) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (sel_rst_s && ena_s && !lock_q && !inc_rise) begin
          state_d = ST_ARM;
          hold_d  = 4'(RST_HOLD - 1);
        end
      end
      ST_ARM: begin
        if (exit_req) begin
          state_d = ST_SELECT;
          lock_d  = 1'b1;
        end else if (hold_q == '0) begin
          state_d = ST_ACTIVE;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      ST_ACTIVE: begin
        if (exit_req) begin
          state_d = ST_SELECT;
          lock_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear has priority over an increment seen in the same cycle.
    if (!sel_rst_s) begin
      addr_d = '0;
    end else if (inc_rise && (state_q != ST_IDLE)) begin
      addr_d = (addr_q == ADDR_W'(N_PROJ - 1)) ? '0 : addr_q + ADDR_W'(1);
    end

    // All registered outputs derive from the next state, so enable, clock gate
    // and project reset change together, and ena is built from a single index.
    clk_en_d = is_live(state_d);
    ena_d    = '0;
    if (clk_en_d) ena_d[addr_d] = 1'b1;
    rst_out_d = (state_d == ST_ACTIVE) && pad_rst_s;
  end

  tt_clk_gate u_clk_gate (
    .clk  (clk),
    .en   (clk_en_q),
    .gclk (gclk)
  );

  always_comb begin
    proj.iw                  = '0;
    proj.iw[IW_UIO +: 8]     = pad_uio_in;
    proj.iw[IW_UI +: 8]      = pad_ui_in;
    proj.iw[IW_RST_N]        = rst_out_q;
    proj.iw[IW_CLK]          = gclk;
  end

  assign proj.ena = ena_q;
  assign sel_addr = addr_q;

  always_comb begin
    ow_sel = '0;
    if (is_live(state_q)) ow_sel = proj.ow[OW_W * 32'(addr_q) +: OW_W];
  end

  assign pad_uo_out  = ow_sel[OW_UO +: 8];
  assign pad_uio_out = ow_sel[OW_UIO_OUT +: 8];
  assign pad_uio_oe  = ow_sel[OW_UIO_OE +: 8];

endmodule

// File: tb/tb_tt_proj_select_ctrl.sv
module tb_tt_proj_select_ctrl;

  localparam int unsigned NP = 16;
  localparam int unsigned RH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, pad_rst_n;
  logic [7:0] pad_ui_in, pad_uio_in;
  logic [7:0] pad_uo_out, pad_uio_out, pad_uio_oe;
  logic [3:0] sel_addr;

  tt_proj_select_ctrl_if #(.N_PROJ(NP)) bus ();

  tt_proj_select_ctrl #(
    .N_PROJ   (NP),
    .RST_HOLD (RH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena),
    .pad_rst_n      (pad_rst_n),
    .pad_ui_in      (pad_ui_in),
    .pad_uio_in     (pad_uio_in),
    .pad_uo_out     (pad_uo_out),
    .pad_uio_out    (pad_uio_out),
    .pad_uio_oe     (pad_uio_oe),
    .proj           (bus),
    .sel_addr       (sel_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      ctrl_sel_inc = 1'b1;
      cyc(4);
      ctrl_sel_inc = 1'b0;
      cyc(4);
    end
  endtask

  task automatic clear_sel();
    ctrl_sel_rst_n = 1'b0;
    cyc(4);
    ctrl_sel_rst_n = 1'b1;
    cyc(4);
  endtask

  task automatic wait_ena();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ena != '0) break;
    end
  endtask

  // Gated clock glitch checker: every high pulse must start with clk high and
  // last exactly half a clk period.
  wire  gclk_w = bus.iw[0];
  time  t_rise;
  bit   have_rise = 1'b0;
  int   runts = 0;
  int   gpulses = 0;

  always @(posedge gclk_w) begin
    t_rise    = $time;
    have_rise = 1'b1;
    gpulses++;
    if (clk !== 1'b1) runts++;
  end

  always @(negedge gclk_w) begin
    if (have_rise && ($time - t_rise != 5)) runts++;
    have_rise = 1'b0;
  end

  // Enable monitors.
  bit counting = 1'b0;
  bit watch4   = 1'b0;
  int twohot = 0;
  int ena_in_count = 0;
  int ena4_seen = 0;

  always @(negedge clk) begin
    if ($countones(bus.ena) > 1) twohot++;
    if (counting && bus.ena != '0) ena_in_count++;
    if (watch4 && bus.ena[4]) ena4_seen++;
  end

  typedef struct {
    logic [23:0] ow5;
    logic [23:0] noise;
    logic [7:0]  ui;
    logic [7:0]  uio;
    logic [7:0]  exp_uo;
    logic [7:0]  exp_uio_out;
    logic [7:0]  exp_oe;
    logic [15:0] exp_iw_hi;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    int g0;

    vecs[0] = '{24'hA5_3C_F0, 24'h00_00_00, 8'h81, 8'h00, 8'hF0, 8'h3C, 8'hA5, 16'h0081};
    vecs[1] = '{24'h00_FF_00, 24'hFF_FF_FF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 16'hFF00};
    vecs[2] = '{24'hFF_00_0F, 24'h12_34_56, 8'h5A, 8'hA5, 8'h0F, 8'h00, 8'hFF, 16'hA55A};
    vecs[3] = '{24'h12_34_56, 24'hAB_CD_EF, 8'h7E, 8'h01, 8'h56, 8'h34, 8'h12, 16'h017E};

    rst_n          = 1'b0;
    ctrl_sel_rst_n = 1'b1;
    ctrl_sel_inc   = 1'b0;
    ctrl_ena       = 1'b0;
    pad_rst_n      = 1'b1;
    pad_ui_in      = 8'h00;
    pad_uio_in     = 8'h00;
    bus.ow         = '1;

    // Reset and idle: outputs forced low even with every slice driving ones.
    cyc(3);
    chk("reset_ena", 32'(bus.ena), 32'h0);
    chk("reset_sel_addr", 32'(sel_addr), 32'h0);
    chk("reset_iw_rst_n", 32'(bus.iw[1]), 32'h0);
    chk("reset_uo_out", 32'(pad_uo_out), 32'h0);
    chk("reset_uio_oe", 32'(pad_uio_oe), 32'h0);
    rst_n = 1'b1;
    cyc(6);
    chk("idle_uio_out", 32'(pad_uio_out), 32'h0);
    chk("idle_ena", 32'(bus.ena), 32'h0);

    // Select project 5.
    bus.ow = '0;
    clear_sel();
    chk("clear_sel_addr", 32'(sel_addr), 32'h0);
    counting = 1'b1;
    pulse_inc(5);
    counting = 1'b0;
    chk("sel5_addr", 32'(sel_addr), 32'h5);
    ctrl_ena = 1'b1;
    wait_ena();
    chk("sel5_ena", 32'(bus.ena), 32'h0020);
    g0 = gpulses;
    n  = 0;
    while (bus.iw[1] === 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("hold_low_cycles", 32'(n), 32'(RH));
    chk("hold_gclk_pulses", 32'(gpulses - g0), 32'(RH));
    cyc(1);
    pad_rst_n = 1'b0;
    cyc(4);
    chk("track_pad_rst_low", 32'(bus.iw[1]), 32'h0);
    pad_rst_n = 1'b1;
    cyc(4);
    chk("track_pad_rst_high", 32'(bus.iw[1]), 32'h1);

    // Data path vectors on project 5, neighbours 4 and 6 carry noise.
    for (int i = 0; i < 4; i++) begin
      bus.ow            = '0;
      bus.ow[5*24 +: 24] = vecs[i].ow5;
      bus.ow[4*24 +: 24] = vecs[i].noise;
      bus.ow[6*24 +: 24] = vecs[i].noise;
      pad_ui_in  = vecs[i].ui;
      pad_uio_in = vecs[i].uio;
      #1;
      chk($sformatf("dp%0d_uo_out", i), 32'(pad_uo_out), 32'(vecs[i].exp_uo));
      chk($sformatf("dp%0d_uio_out", i), 32'(pad_uio_out), 32'(vecs[i].exp_uio_out));
      chk($sformatf("dp%0d_uio_oe", i), 32'(pad_uio_oe), 32'(vecs[i].exp_oe));
      chk($sformatf("dp%0d_iw_uio_ui", i), 32'(bus.iw[17:2]), 32'(vecs[i].exp_iw_hi));
      cyc(1);
    end

    // Wrap: 17 increments from 0 land on 1, with no enable while counting.
    ctrl_ena = 1'b0;
    cyc(5);
    chk("exit_on_ena_low", 32'(bus.ena), 32'h0);
    chk("exit_uo_zero", 32'(pad_uio_oe), 32'h0);
    clear_sel();
    counting = 1'b1;
    pulse_inc(17);
    counting = 1'b0;
    chk("wrap_addr", 32'(sel_addr), 32'h1);
    chk("no_ena_while_counting", 32'(ena_in_count), 32'h0);

    // Exit from ACTIVE on project 3 via an increment.
    clear_sel();
    pulse_inc(3);
    chk("sel3_addr", 32'(sel_addr), 32'h3);
    ctrl_ena = 1'b1;
    wait_ena();
    chk("sel3_ena", 32'(bus.ena), 32'h0008);
    cyc(8);
    chk("sel3_active_rst_n", 32'(bus.iw[1]), 32'h1);
    watch4 = 1'b1;
    pulse_inc(1);
    cyc(6);
    chk("exit_inc_ena", 32'(bus.ena), 32'h0);
    chk("exit_inc_addr", 32'(sel_addr), 32'h4);
    chk("exit_inc_rst_n", 32'(bus.iw[1]), 32'h0);
    watch4 = 1'b0;
    chk("ena4_held_off", 32'(ena4_seen), 32'h0);
    ctrl_ena = 1'b0;
    cyc(4);
    ctrl_ena = 1'b1;
    wait_ena();
    chk("reactivate_ena4", 32'(bus.ena), 32'h0010);

    // Clear and increment landing in the same synchronised cycle.
    ctrl_ena = 1'b0;
    cyc(4);
    pulse_inc(2);
    chk("pre_simul_addr", 32'(sel_addr), 32'h6);
    ctrl_sel_rst_n = 1'b0;
    ctrl_sel_inc   = 1'b1;
    cyc(5);
    chk("simul_clear_wins", 32'(sel_addr), 32'h0);
    ctrl_sel_rst_n = 1'b1;
    ctrl_sel_inc   = 1'b0;
    cyc(5);
    chk("simul_after_release", 32'(sel_addr), 32'h0);

    // Asynchronous reset while ACTIVE on project 0.
    bus.ow           = '0;
    bus.ow[0 +: 24]  = 24'hC3_99_7E;
    ctrl_ena = 1'b1;
    wait_ena();
    chk("sel0_ena", 32'(bus.ena), 32'h0001);
    cyc(8);
    chk("sel0_uo_out", 32'(pad_uo_out), 32'h7E);
    chk("sel0_rst_n", 32'(bus.iw[1]), 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ena", 32'(bus.ena), 32'h0);
    chk("async_rst_uo_out", 32'(pad_uo_out), 32'h0);
    chk("async_rst_uio_oe", 32'(pad_uio_oe), 32'h0);
    chk("async_rst_iw_rst_n", 32'(bus.iw[1]), 32'h0);
    chk("async_rst_sel_addr", 32'(sel_addr), 32'h0);
    cyc(3);

    chk("gclk_runts", 32'(runts), 32'h0);
    chk("ena_two_hot", 32'(twohot), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
